fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue RV32I core. It owns the program counter, presents the PC as a byte address to the combinational instruction memory (word-indexed by byte address, one instruction every 4 bytes), and captures the returned instruction into the IF/ID pipeline register. Decode consumes that register through a valid/ready handshake. Branch and jump redirects, flushes and fetch faults are resolved here.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IMEM_BYTES, 256, size of the fetchable address window in bytes; PCs at or above it fault

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to instruction memory; always equals pc
- imem_rdata  in  32  instruction returned combinationally for imem_addr
- redirect_valid  in  1  branch/jump taken; load redirect_pc and flush
- redirect_pc  in  32  redirect target, byte address
- out_valid  out  1  IF/ID register holds a valid instruction
- out_ready  in  1  decode accepts IF/ID this cycle
- out_instr  out  32  fetched instruction
- out_pc  out  32  PC of out_instr
- out_pc_plus4  out  32  out_pc + 4
- fetch_fault  out  1  stage halted on a misaligned or out-of-window PC
- fault_pc  out  32  offending PC, valid while fetch_fault=1
- fetch_count  out  32  number of instructions accepted by decode

## Operation
- States: BOOT, RUN, TRAP.
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fetch_fault=0, fault_pc=0, fetch_count=0.
- BOOT: lasts exactly one cycle after rst_n rises, with no fetch; then RUN.
- RUN, load condition: load = !out_valid || out_ready.
- On load with a good pc: out_instr<=imem_rdata, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
- A pc is bad if pc[1:0]!=0 or pc>=IMEM_BYTES. On load with a bad pc: state<=TRAP, fetch_fault<=1, fault_pc<=pc, out_valid<=0, pc unchanged.
- No load (out_valid=1, out_ready=0): all IF/ID outputs and pc hold.
- Redirect has highest priority, in any state except BOOT: pc<=redirect_pc, out_valid<=0, and no capture that cycle. If in TRAP: state<=RUN, fetch_fault<=0. Target checking happens at the next load, so a bad target enters TRAP one cycle later.
- Redirect in BOOT is ignored.
- TRAP: out_valid=0; pc, fault_pc and fetch_fault hold; only a redirect leaves TRAP.
- fetch_count increments by 1 (mod 2^32) on every cycle with out_valid && out_ready, including a cycle that also carries a redirect.
- Arithmetic: pc+4 is 32-bit and wraps. A wrapped pc is checked against IMEM_BYTES like any other.

## Timing
- imem_addr = pc combinationally; imem_rdata is sampled at the same edge that updates pc.
- Fetch latency: the instruction at pc appears on out_instr one cycle after pc is presented.
- Throughput: 1 instruction/cycle while out_ready=1.
- First out_valid=1 is the 2nd rising edge after rst_n deasserts (BOOT edge, then first fetch edge).
- Redirect: out_valid=0 in the cycle after redirect_valid; the target's instruction is valid on the following cycle. Redirect penalty is 1 bubble.
- out_ready may be asserted while out_valid=0; this has no effect.
- out_valid never drops without a handshake, except on a redirect or a fault.
- rst_n asserted mid-stream: all outputs return to their reset values immediately, independent of clk.

## Test plan
- Reset/boot: memory word@0=0x00500113, @4=0x00c00193; release rst_n, hold out_ready=1 -> cycle 2: out_valid=1, out_instr=0x00500113, out_pc=0, out_pc_plus4=4; cycle 3: out_instr=0x00c00193, out_pc=4; fetch_count=2 after cycle 3.
- Backpressure: out_ready=0 for 3 cycles while holding pc=8 instruction -> out_instr, out_pc=8 and pc=12 stable; fetch_count unchanged; on release, next out_pc=12.
- Redirect: redirect_valid=1, redirect_pc=0x40 while out_pc=0x10 is accepted -> fetch_count increments; next cycle out_valid=0; following cycle out_pc=0x40, out_instr=mem[0x40].
- Misaligned redirect: redirect_pc=0x22 -> one bubble, then fetch_fault=1, fault_pc=0x22, out_valid=0 held for 5 cycles; redirect_pc=0x0 -> fetch_fault=0, out_pc=0 valid 2 cycles later.
- Window end: run sequentially to pc=0xFC then 0x100 -> 0xFC delivered; fetch_fault=1, fault_pc=0x100.
- Async reset mid-run: drop rst_n between clock edges -> out_valid, fetch_count, fetch_fault and pc reset immediately.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus, redirect input and IF/ID handshake of the fetch stage
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_pc_plus4,
      output fetch_fault,
      output fault_pc,
      output fetch_count
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_pc_plus4,
      input  fetch_fault,
      input  fault_pc,
      input  fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from combinational imem into the IF/ID register, handles redirects and fetch faults
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 256
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] opc_q, opc_n;
   logic [31:0] opc4_q, opc4_n;
   logic [31:0] fpc_q, fpc_n;
   logic [31:0] cnt_q, cnt_n;
   logic        ov_q, ov_n;
   logic        ff_q, ff_n;
   logic        hs, load, bad;

   assign hs   = ov_q && bus.out_ready;
   assign load = !ov_q || bus.out_ready;
   assign bad  = (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);

   assign bus.imem_addr    = pc;
   assign bus.out_valid    = ov_q;
   assign bus.out_instr    = instr_q;
   assign bus.out_pc       = opc_q;
   assign bus.out_pc_plus4 = opc4_q;
   assign bus.fetch_fault  = ff_q;
   assign bus.fault_pc     = fpc_q;
   assign bus.fetch_count  = cnt_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_n;
   end

   // Next state and datapath: redirect beats capture; a bad PC is only detected when it would be loaded
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr_q;
      opc_n   = opc_q;
      opc4_n  = opc4_q;
      ov_n    = ov_q;
      ff_n    = ff_q;
      fpc_n   = fpc_q;
      cnt_n   = cnt_q + {31'b0, hs};
      case (state)
         BOOT: state_n = RUN;
         RUN: begin
            if (bus.redirect_valid) begin
               pc_n = bus.redirect_pc;
               ov_n = 1'b0;
            end else if (load && bad) begin
               state_n = TRAP;
               ff_n    = 1'b1;
               fpc_n   = pc;
               ov_n    = 1'b0;
            end else if (load) begin
               instr_n = bus.imem_rdata;
               opc_n   = pc;
               opc4_n  = pc + 32'd4;
               ov_n    = 1'b1;
               pc_n    = pc + 32'd4;
            end
         end
         TRAP: begin
            ov_n = 1'b0;
            if (bus.redirect_valid) begin
               state_n = RUN;
               ff_n    = 1'b0;
               pc_n    = bus.redirect_pc;
            end
         end
         default: state_n = BOOT;
      endcase
   end

   // PC, IF/ID register, fault capture and accepted-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         instr_q <= '0;
         opc_q   <= '0;
         opc4_q  <= '0;
         ov_q    <= 1'b0;
         ff_q    <= 1'b0;
         fpc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         pc      <= pc_n;
         instr_q <= instr_n;
         opc_q   <= opc_n;
         opc4_q  <= opc4_n;
         ov_q    <= ov_n;
         ff_q    <= ff_n;
         fpc_q   <= fpc_n;
         cnt_q   <= cnt_n;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a combinational memory model
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] mem [64];
   logic [31:0] q [$];
   int n_cmp = 0;
   int n_err = 0;
   int hs_cnt = 0;

   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a < 32'd256) ? mem[a[7:2]] : 32'hdead_beef;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic mon();
      logic [31:0] e;
      if (bus.out_valid && bus.out_ready) begin
         hs_cnt++;
         if (q.size() == 0) chk("unexpected_hs", bus.out_pc, 32'hffff_ffff);
         else begin
            e = q.pop_front();
            chk("sb_pc", bus.out_pc, e);
            chk("sb_instr", bus.out_instr, mem_word(e));
            chk("sb_pc4", bus.out_pc_plus4, e + 32'd4);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_cnt(input string tag);
      chk(tag, bus.fetch_count, hs_cnt);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1357_0013 + i * 32'h0001_0203;
      mem[0] = 32'h0050_0113;
      mem[1] = 32'h00c0_0193;
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      tick();
      tick();
      chk("rst_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_pc", bus.imem_addr, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_instr", bus.out_instr, 0);
      chk("rst_fault", {31'b0, bus.fetch_fault}, 0);
      chk("rst_count", bus.fetch_count, 0);
      q.push_back(32'h0);
      q.push_back(32'h4);
      q.push_back(32'h8);
      rst_n = 1'b1;
      tick();
      chk("boot_valid", {31'b0, bus.out_valid}, 0);
      chk("boot_pc", bus.imem_addr, 0);
      tick();
      chk("first_valid", {31'b0, bus.out_valid}, 1);
      chk("first_instr", bus.out_instr, 32'h0050_0113);
      chk("first_pc", bus.out_pc, 0);
      chk("first_pc4", bus.out_pc_plus4, 4);
      tick();
      chk("second_instr", bus.out_instr, 32'h00c0_0193);
      chk("second_pc", bus.out_pc, 4);
      tick();
      chk_cnt("cnt_seq");
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_out_pc", bus.out_pc, 8);
         chk("bp_instr", bus.out_instr, mem[2]);
         chk("bp_pc", bus.imem_addr, 12);
         chk_cnt("bp_cnt");
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release", bus.out_pc, 12);
      q.push_back(32'hc);
      tick();
      chk("pre_redir", bus.out_pc, 32'h10);
      q.push_back(32'h10);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      tick();
      bus.redirect_valid = 1'b0;
      chk("redir_bubble", {31'b0, bus.out_valid}, 0);
      chk("redir_pc", bus.imem_addr, 32'h40);
      chk_cnt("redir_cnt");
      tick();
      chk("redir_valid", {31'b0, bus.out_valid}, 1);
      chk("redir_out_pc", bus.out_pc, 32'h40);
      chk("redir_instr", bus.out_instr, mem[16]);
      q.push_back(32'h40);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h22;
      tick();
      bus.redirect_valid = 1'b0;
      chk("mis_bubble", {31'b0, bus.out_valid}, 0);
      chk("mis_nofault", {31'b0, bus.fetch_fault}, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mis_fault", {31'b0, bus.fetch_fault}, 1);
         chk("mis_fault_pc", bus.fault_pc, 32'h22);
         chk("mis_valid", {31'b0, bus.out_valid}, 0);
         chk("mis_pc", bus.imem_addr, 32'h22);
      end
      chk_cnt("trap_cnt");
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      tick();
      bus.redirect_valid = 1'b0;
      chk("unfault", {31'b0, bus.fetch_fault}, 0);
      chk("unfault_valid", {31'b0, bus.out_valid}, 0);
      tick();
      chk("resume_valid", {31'b0, bus.out_valid}, 1);
      chk("resume_pc", bus.out_pc, 0);
      q.push_back(32'h0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hf0;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) q.push_back(32'hf0 + 32'(i) * 32'd4);
      for (int i = 0; i < 4; i++) tick();
      chk("win_last", bus.out_pc, 32'hfc);
      tick();
      chk("win_fault", {31'b0, bus.fetch_fault}, 1);
      chk("win_fault_pc", bus.fault_pc, 32'h100);
      chk("win_valid", {31'b0, bus.out_valid}, 0);
      chk_cnt("win_cnt");
      chk("q_empty1", q.size(), 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h10;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      q.push_back(32'h10);
      tick();
      chk("pre_arst", bus.out_pc, 32'h14);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, bus.out_valid}, 0);
      chk("arst_count", bus.fetch_count, 0);
      chk("arst_pc", bus.imem_addr, 0);
      chk("arst_out_pc", bus.out_pc, 0);
      q.delete();
      hs_cnt = 0;
      tick();
      tick();
      rst_n = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h80;
      tick();
      bus.redirect_valid = 1'b0;
      chk("boot_redir_ign", bus.imem_addr, 0);
      tick();
      chk("reboot_pc", bus.out_pc, 0);
      chk("reboot_valid", {31'b0, bus.out_valid}, 1);
      q.push_back(32'h0);
      tick();
      bus.out_ready = 1'b0;
      tick();
      chk_cnt("end_cnt");
      chk("q_empty2", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
